// File: rtl/spi_frame_sequencer.sv
// Buffers {last, dc, byte} entries and feeds them one at a time to the byte-level
// SPI controller, owning display chip-select and D/C framing around each transaction.
module spi_frame_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_wr_valid,
  input  logic                        i_wr_dc,
  input  logic [7:0]                  i_wr_byte,
  input  logic                        i_wr_last,
  output logic                        o_wr_ready,
  output logic [7:0]                  o_tx_byte,
  output logic                        o_tx_dv,
  input  logic                        i_tx_ready,
  output logic                        o_lcd_cs_n,
  output logic                        o_lcd_dc,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic [2:0]                  o_dbg_state
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int CMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int TW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    HOLD      = 3'd5
  } state_t;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [9:0]    head;
  logic          fifo_empty, wr_en, pop;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          cs_n_q, cs_n_d;
  logic          dc_q, dc_d;
  logic [7:0]    byte_q, byte_d;
  logic          last_q, last_d;

  // Handshakes: an upstream entry transfers on a cycle where i_wr_valid & o_wr_ready;
  // a byte transfers to the controller on the single cycle o_tx_dv is high, which only
  // happens while i_tx_ready is high, and the controller drops ready the cycle after.
  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign o_wr_ready = (count_q < CW'(FIFO_DEPTH));
  assign wr_en      = i_wr_valid & o_wr_ready;
  assign pop        = (state_q == ISSUE) && !fifo_empty && i_tx_ready;

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {i_wr_last, i_wr_dc, i_wr_byte};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && !pop)      count_q <= count_q + 1'b1;
      else if (!wr_en && pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b0;
      byte_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      dc_q    <= dc_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_n_d  = cs_n_q;
    dc_d    = dc_q;
    byte_d  = byte_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          cs_n_d  = 1'b0;
          dc_d    = head[8];
          cnt_d   = TW'(CS_SETUP - 1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) state_d = ISSUE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ISSUE: begin
        if (pop) begin
          dc_d    = head[8];
          byte_d  = head[7:0];
          last_d  = head[9];
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!i_tx_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_tx_ready) begin
          if (last_q) begin
            cnt_d   = TW'(CS_HOLD - 1);
            state_d = HOLD;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          cs_n_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The pop cycle presents the head directly so dv lands exactly CS_SETUP cycles after
  // CS falls; CS is released in the final hold cycle so the gap after completion is CS_HOLD.
  assign o_tx_dv      = pop;
  assign o_tx_byte    = pop ? head[7:0] : byte_q;
  assign o_lcd_dc     = pop ? head[8] : dc_q;
  assign o_lcd_cs_n   = cs_n_q | ((state_q == HOLD) && (cnt_q == '0));
  assign o_busy       = (state_q != IDLE) || !fifo_empty;
  assign o_fifo_count = count_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench for spi_frame_sequencer: a small SPI controller model, a negedge
// monitor that captures each issued {dc, byte} and framing timing, and scenario tasks.
module tb_spi_frame_sequencer;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int SHIFT = 3;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;

  logic          clk, rst_n;
  logic          wr_valid, wr_dc, wr_last, wr_ready;
  logic [7:0]    wr_byte, tx_byte;
  logic          tx_dv, tx_ready, cs_n, dc, busy;
  logic [CW-1:0] fifo_count;
  logic [2:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  // monitor state (written only by the monitor process)
  int   cyc = 0, dv_cnt = 0, dv_bad = 0, dc_err = 0, cs_rise_cnt = 0;
  int   setup_gap = -1, hold_gap = -1, cs_fall_cyc = 0, ready_rise_cyc = 0;
  logic cs_n_prev = 1'b1, rdy_prev = 1'b1, inflight = 1'b0, inflight_dc = 1'b0;
  logic first_dv_pending = 1'b0;

  // per-test baselines (written only by the stimulus process)
  int gb, db, bb, eb, rb;

  logic hold_nr;
  int   shift_cnt;

  spi_frame_sequencer #(.FIFO_DEPTH(DEPTH), .CS_SETUP(2), .CS_HOLD(2)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wr_valid(wr_valid), .i_wr_dc(wr_dc), .i_wr_byte(wr_byte), .i_wr_last(wr_last),
    .o_wr_ready(wr_ready),
    .o_tx_byte(tx_byte), .o_tx_dv(tx_dv), .i_tx_ready(tx_ready),
    .o_lcd_cs_n(cs_n), .o_lcd_dc(dc), .o_busy(busy), .o_fifo_count(fifo_count),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // SPI controller model: registered ready, drops after dv, back after SHIFT+1 cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready  <= 1'b1;
      shift_cnt <= 0;
    end else if (tx_dv && tx_ready) begin
      tx_ready  <= 1'b0;
      shift_cnt <= SHIFT;
    end else if (shift_cnt > 0) begin
      shift_cnt <= shift_cnt - 1;
    end else begin
      tx_ready <= !hold_nr;
    end
  end

  // monitor
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      cs_n_prev = 1'b1;
      rdy_prev = 1'b1;
      inflight = 1'b0;
      first_dv_pending = 1'b0;
    end else begin
      if (cs_n_prev && !cs_n) begin cs_fall_cyc = cyc; first_dv_pending = 1'b1; end
      if (!cs_n_prev && cs_n) begin cs_rise_cnt++; hold_gap = cyc - ready_rise_cyc; end
      if (!rdy_prev && tx_ready) ready_rise_cyc = cyc;
      if (tx_dv) begin
        got_q.push_back({dc, tx_byte});
        dv_cnt++;
        if (!tx_ready) dv_bad++;
        if (first_dv_pending) begin setup_gap = cyc - cs_fall_cyc; first_dv_pending = 1'b0; end
        inflight = 1'b1;
        inflight_dc = dc;
      end else if (inflight) begin
        if (dc !== inflight_dc) dc_err++;
        if (tx_ready) inflight = 1'b0;
      end
      cs_n_prev = cs_n;
      rdy_prev = tx_ready;
    end
  end

  // driver tasks
  task automatic snap();
    gb = got_q.size(); db = dv_cnt; bb = dv_bad; eb = dc_err; rb = cs_rise_cnt;
    exp_q.delete();
  endtask

  task automatic push(input logic l, input logic d, input logic [7:0] b);
    @(negedge clk);
    wr_valid = 1'b1; wr_last = l; wr_dc = d; wr_byte = b;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || !cs_n) && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) begin
      n_cmp++; n_err++;
      $display("FAIL %s_idle_timeout busy=%b cs_n=%b required busy=0 cs_n=1", name, busy, cs_n);
    end
    repeat (2) @(negedge clk);
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 1'b0; wr_dc = 1'b0; wr_last = 1'b0; wr_byte = '0; hold_nr = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (cs_n !== 1'b1)   begin n_err++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
    n_cmp++; if (dc !== 1'b0)     begin n_err++; $display("FAIL reset_dc got=%b exp=0", dc); end
    n_cmp++; if (tx_dv !== 1'b0)  begin n_err++; $display("FAIL reset_tx_dv got=%b exp=0", tx_dv); end
    n_cmp++; if (tx_byte !== 8'h00) begin n_err++; $display("FAIL reset_tx_byte got=%h exp=00", tx_byte); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (fifo_count !== '0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single(input string name);
    snap();
    exp_q.push_back({1'b0, 8'h2A});
    push(1'b1, 1'b0, 8'h2A);
    wait_idle(name);
    n_cmp++; if (dv_cnt - db !== 1) begin n_err++; $display("FAIL %s_dv_count got=%0d exp=1", name, dv_cnt - db); end
    n_cmp++; if (got_q.size() - gb !== 1) begin n_err++; $display("FAIL %s_len got=%0d exp=1", name, got_q.size() - gb); end
    if (got_q.size() > gb) begin
      n_cmp++; if (got_q[gb] !== exp_q[0]) begin n_err++; $display("FAIL %s_item got=%h exp=%h", name, got_q[gb], exp_q[0]); end
    end
    n_cmp++; if (setup_gap !== 2) begin n_err++; $display("FAIL %s_setup_gap got=%0d exp=2", name, setup_gap); end
    n_cmp++; if (hold_gap !== 2)  begin n_err++; $display("FAIL %s_hold_gap got=%0d exp=2", name, hold_gap); end
    n_cmp++; if (cs_rise_cnt - rb !== 1) begin n_err++; $display("FAIL %s_cs_rises got=%0d exp=1", name, cs_rise_cnt - rb); end
    n_cmp++; if (busy !== 1'b0 || cs_n !== 1'b1) begin n_err++; $display("FAIL %s_after busy=%b cs_n=%b exp busy=0 cs_n=1", name, busy, cs_n); end
    n_cmp++; if (dc_err - eb !== 0 || dv_bad - bb !== 0) begin n_err++; $display("FAIL %s_dc_dv_rules dc_err=%0d dv_bad=%0d exp 0", name, dc_err - eb, dv_bad - bb); end
  endtask

  task automatic test_frame();
    snap();
    exp_q.push_back({1'b0, 8'h2C});
    exp_q.push_back({1'b1, 8'hF8});
    exp_q.push_back({1'b1, 8'h00});
    push(1'b0, 1'b0, 8'h2C);
    push(1'b0, 1'b1, 8'hF8);
    push(1'b1, 1'b1, 8'h00);
    wait_idle("frame");
    n_cmp++; if (got_q.size() - gb !== 3) begin n_err++; $display("FAIL frame_len got=%0d exp=3", got_q.size() - gb); end
    foreach (exp_q[i]) if (gb + i < got_q.size()) begin
      n_cmp++; if (got_q[gb + i] !== exp_q[i]) begin n_err++; $display("FAIL frame_item%0d got=%h exp=%h", i, got_q[gb + i], exp_q[i]); end
    end
    n_cmp++; if (cs_rise_cnt - rb !== 1) begin n_err++; $display("FAIL frame_cs_rises got=%0d exp=1", cs_rise_cnt - rb); end
    n_cmp++; if (dc_err - eb !== 0) begin n_err++; $display("FAIL frame_dc_stable errors=%0d exp=0", dc_err - eb); end
    n_cmp++; if (hold_gap !== 2) begin n_err++; $display("FAIL frame_hold_gap got=%0d exp=2", hold_gap); end
  endtask

  task automatic test_full();
    logic [7:0] b;
    snap();
    hold_nr = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 16) begin
        n_cmp++; if (wr_ready !== 1'b0 || fifo_count !== CW'(16)) begin n_err++; $display("FAIL full_at16 wr_ready=%b count=%0d exp 0/16", wr_ready, fifo_count); end
      end
      b = 8'h40 + 8'(i);
      wr_valid = 1'b1; wr_last = (i >= 15); wr_dc = i[0]; wr_byte = b;
      if (i < 16) exp_q.push_back({wr_dc, b});
    end
    @(negedge clk);
    wr_valid = 1'b0;
    n_cmp++; if (fifo_count !== CW'(16)) begin n_err++; $display("FAIL full_count got=%0d exp=16", fifo_count); end
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL full_wr_ready got=%b exp=0", wr_ready); end
    n_cmp++; if (dv_cnt - db !== 0) begin n_err++; $display("FAIL full_no_dv got=%0d exp=0", dv_cnt - db); end
    hold_nr = 1'b0;
    wait_idle("full");
    n_cmp++; if (fifo_count !== '0) begin n_err++; $display("FAIL full_drained got=%0d exp=0", fifo_count); end
    n_cmp++; if (got_q.size() - gb !== 16) begin n_err++; $display("FAIL full_len got=%0d exp=16", got_q.size() - gb); end
    foreach (exp_q[i]) if (gb + i < got_q.size()) begin
      n_cmp++; if (got_q[gb + i] !== exp_q[i]) begin n_err++; $display("FAIL full_item%0d got=%h exp=%h", i, got_q[gb + i], exp_q[i]); end
    end
    n_cmp++; if (cs_rise_cnt - rb !== 1) begin n_err++; $display("FAIL full_cs_rises got=%0d exp=1", cs_rise_cnt - rb); end
    n_cmp++; if (dv_bad - bb !== 0) begin n_err++; $display("FAIL full_dv_while_busy got=%0d exp=0", dv_bad - bb); end
  endtask

  task automatic test_starve();
    int n, cs_high;
    snap();
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h55});
    push(1'b0, 1'b0, 8'h11);
    n = 0;
    while (dv_cnt == db && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin n_cmp++; n_err++; $display("FAIL starve_dv_timeout dv=%0d exp=1", dv_cnt - db); end
    repeat (SHIFT + 4) @(negedge clk);
    cs_high = 0;
    repeat (20) begin @(negedge clk); if (cs_n) cs_high++; end
    n_cmp++; if (dv_cnt - db !== 1) begin n_err++; $display("FAIL starve_gap_dv got=%0d exp=1", dv_cnt - db); end
    n_cmp++; if (cs_high !== 0) begin n_err++; $display("FAIL starve_gap_cs_high cycles=%0d exp=0", cs_high); end
    n_cmp++; if (dbg_state !== ST_ISSUE) begin n_err++; $display("FAIL starve_state got=%0d exp=%0d", dbg_state, ST_ISSUE); end
    push(1'b1, 1'b1, 8'h55);
    wait_idle("starve");
    n_cmp++; if (got_q.size() - gb !== 2) begin n_err++; $display("FAIL starve_len got=%0d exp=2", got_q.size() - gb); end
    foreach (exp_q[i]) if (gb + i < got_q.size()) begin
      n_cmp++; if (got_q[gb + i] !== exp_q[i]) begin n_err++; $display("FAIL starve_item%0d got=%h exp=%h", i, got_q[gb + i], exp_q[i]); end
    end
    n_cmp++; if (cs_rise_cnt - rb !== 1) begin n_err++; $display("FAIL starve_cs_rises got=%0d exp=1", cs_rise_cnt - rb); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    snap();
    hold_nr = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b = 8'hA0 + 8'(i);
      wr_valid = 1'b1; wr_last = 1'b0; wr_dc = i[0]; wr_byte = b;
      exp_q.push_back({wr_dc, b});
    end
    @(negedge clk);
    wr_valid = 1'b0;
    n_cmp++; if (fifo_count !== CW'(5)) begin n_err++; $display("FAIL simul_pre_count got=%0d exp=5", fifo_count); end
    hold_nr = 1'b0;
    @(negedge clk);
    n_cmp++; if (tx_dv !== 1'b1) begin n_err++; $display("FAIL simul_pop_now got=%b exp=1", tx_dv); end
    wr_valid = 1'b1; wr_last = 1'b1; wr_dc = 1'b1; wr_byte = 8'hA5;
    exp_q.push_back({1'b1, 8'hA5});
    @(negedge clk);
    wr_valid = 1'b0;
    n_cmp++; if (fifo_count !== CW'(5)) begin n_err++; $display("FAIL simul_count got=%0d exp=5", fifo_count); end
    wait_idle("simul");
    n_cmp++; if (got_q.size() - gb !== 6) begin n_err++; $display("FAIL simul_len got=%0d exp=6", got_q.size() - gb); end
    foreach (exp_q[i]) if (gb + i < got_q.size()) begin
      n_cmp++; if (got_q[gb + i] !== exp_q[i]) begin n_err++; $display("FAIL simul_item%0d got=%h exp=%h", i, got_q[gb + i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    snap();
    push(1'b0, 1'b0, 8'h77);
    push(1'b1, 1'b1, 8'h78);
    n = 0;
    while (dbg_state !== ST_WAIT_DONE && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin n_cmp++; n_err++; $display("FAIL rstmid_wait_done_timeout state=%0d exp=%0d", dbg_state, ST_WAIT_DONE); end
    n_cmp++; if (cs_n !== 1'b0 || fifo_count !== CW'(1)) begin n_err++; $display("FAIL rstmid_pre cs_n=%b count=%0d exp 0/1", cs_n, fifo_count); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cs_n !== 1'b1) begin n_err++; $display("FAIL rstmid_cs_n got=%b exp=1", cs_n); end
    n_cmp++; if (tx_dv !== 1'b0) begin n_err++; $display("FAIL rstmid_tx_dv got=%b exp=0", tx_dv); end
    n_cmp++; if (fifo_count !== '0) begin n_err++; $display("FAIL rstmid_count got=%0d exp=0", fifo_count); end
    n_cmp++; if (busy !== 1'b0 || wr_ready !== 1'b1 || dc !== 1'b0) begin n_err++; $display("FAIL rstmid_misc busy=%b wr_ready=%b dc=%b exp 0/1/0", busy, wr_ready, dc); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_single("post_reset");
  endtask

  initial begin
    test_reset();
    test_single("single");
    test_frame();
    test_full();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
